char_pwm_decoder: RTL

- Receive end of the phase-coded character link.
- Samples the 16 phase-coded pixel lines produced by the character PWM generator against a copy of the generator's reference clock, integrates over a window and recovers the 4x4 pixel pattern.
- Classifies the pattern as one of the 2-bit character codes A/J/N/X.
- Sits on the ASIC-bridge receive side; feeds readback/verification logic with a classified character plus a valid pulse.

---
 rtl/char_pwm_decoder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/char_pwm_decoder.sv
// rtl/char_pwm_decoder.sv - phase-coded 4x4 character receiver; CHAR_DECODE_NEAREST_EN enables nearest-match decoding
module char_pwm_decoder #(
    parameter int WINDOW   = 64,
    parameter int THRESH   = 48,
    parameter int MAX_DIST = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        ref_in,
    input  logic [15:0] digit,
    output logic        busy,
    output logic [15:0] pixels,
    output logic [1:0]  char_out,
    output logic        char_valid,
    output logic        char_err
);

    localparam int CW = $clog2(WINDOW + 1);
    localparam int WW = $clog2(WINDOW);

    localparam logic [15:0] TPL_A = 16'h9F8F;
    localparam logic [15:0] TPL_J = 16'h6998;
    localparam logic [15:0] TPL_N = 16'h9DA9;
    localparam logic [15:0] TPL_X = 16'h9679;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DECIDE = 2'd2
    } state_t;

    state_t          state, state_next;
    logic            ref_s1, ref_s2;
    logic [15:0]     dig_s1, dig_s2;
    logic [15:0]     match;
    logic [CW-1:0]   cnt [16];
    logic [WW-1:0]   win;
    logic [15:0]     pat;
    logic            hit;
    logic [1:0]      code;

    // Two-flop synchronizers for the asynchronous reference and pixel lines
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_s1 <= 1'b0;
            ref_s2 <= 1'b0;
            dig_s1 <= '0;
            dig_s2 <= '0;
        end else begin
            ref_s1 <= ref_in;
            ref_s2 <= ref_s1;
            dig_s1 <= digit;
            dig_s2 <= dig_s1;
        end
    end

    // A pixel line is "on" when it runs in phase with the reference
    assign match = ~(dig_s2 ^ {16{ref_s2}});

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only honoured while idle
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                busy = 1'b1;
                if (win == WW'(WINDOW - 1)) begin
                    state_next = DECIDE;
                end
            end
            DECIDE: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Window counter and per-pixel in-phase counters; cleared when a window starts
    always_ff @(posedge clk) begin
        if (rst) begin
            win <= '0;
            for (int i = 0; i < 16; i++) begin
                cnt[i] <= '0;
            end
        end else if (state == IDLE && start) begin
            win <= '0;
            for (int i = 0; i < 16; i++) begin
                cnt[i] <= '0;
            end
        end else if (state == ACCUM) begin
            win <= win + WW'(1);
            for (int i = 0; i < 16; i++) begin
                cnt[i] <= cnt[i] + CW'(match[i]);
            end
        end
    end

`ifdef CHAR_DECODE_NEAREST_EN
    function automatic logic [15:0] template_of(input logic [1:0] c);
        logic [15:0] t;
        case (c)
            2'd0:    t = TPL_A;
            2'd1:    t = TPL_J;
            2'd2:    t = TPL_N;
            default: t = TPL_X;
        endcase
        return t;
    endfunction

    logic [4:0] dist;
    logic [4:0] best;

    // Threshold the counters, then pick the closest template (ties go to the lower code)
    always_comb begin
        pat  = '0;
        hit  = 1'b0;
        code = 2'b00;
        dist = '0;
        best = 5'd31;
        for (int i = 0; i < 16; i++) begin
            pat[i] = (cnt[i] >= CW'(THRESH));
        end
        for (int c = 0; c < 4; c++) begin
            dist = 5'($countones(pat ^ template_of(2'(c))));
            if (dist < best) begin
                best = dist;
                code = 2'(c);
            end
        end
        hit = (int'(best) <= MAX_DIST);
    end
`else
    logic max_dist_unused;
    assign max_dist_unused = (MAX_DIST < 0);

    // Threshold the counters, then look for an exact template match
    always_comb begin
        pat  = '0;
        hit  = 1'b0;
        code = 2'b00;
        for (int i = 0; i < 16; i++) begin
            pat[i] = (cnt[i] >= CW'(THRESH));
        end
        case (pat)
            TPL_A:   begin hit = 1'b1; code = 2'b00; end
            TPL_J:   begin hit = 1'b1; code = 2'b01; end
            TPL_N:   begin hit = 1'b1; code = 2'b10; end
            TPL_X:   begin hit = 1'b1; code = 2'b11; end
            default: begin hit = 1'b0; code = 2'b00; end
        endcase
    end
`endif

    // Decision outputs; char_out keeps its last good code when nothing matches
    always_ff @(posedge clk) begin
        if (rst) begin
            pixels     <= '0;
            char_out   <= 2'b00;
            char_err   <= 1'b0;
            char_valid <= 1'b0;
        end else begin
            char_valid <= 1'b0;
            if (state == DECIDE) begin
                pixels     <= pat;
                char_valid <= 1'b1;
                char_err   <= ~hit;
                if (hit) begin
                    char_out <= code;
                end
            end
        end
    end

endmodule
